// File: rtl/conv2d_stream_if.sv
// Column-stream bus between the column feeder and conv2d_stream.
// The feeder drives the master side; the convolution engine is the slave.
interface conv2d_stream_if #(
  parameter int BIT_LEN  = 8,
  parameter int K_LEN    = 3,
  parameter int CONV_LEN = 20
);
  logic                       i_valid;
  logic                       i_selecK_I;
  logic [K_LEN*BIT_LEN-1:0]   i_data;
  logic signed [CONV_LEN-1:0] o_data;
  logic                       o_valid;
  logic                       o_kernel_ready;
  logic                       o_err;

  modport master (
    output i_valid, i_selecK_I, i_data,
    input  o_data, o_valid, o_kernel_ready, o_err
  );

  modport slave (
    input  i_valid, i_selecK_I, i_data,
    output o_data, o_valid, o_kernel_ready, o_err
  );
endinterface

// File: rtl/conv2d_stream.sv
// Streaming K_LEN x K_LEN signed convolution: kernel/window capture, product stage, adder-tree stage.
// Optional macro CONV_RELU_EN clamps negative results to zero in the output stage.
module conv2d_stream #(
  parameter int BIT_LEN  = 8,
  parameter int K_LEN    = 3,
  parameter int CONV_LEN = 20
) (
  input  logic            i_clk,
  input  logic            i_reset,
  conv2d_stream_if.slave  bus
);

  localparam int PW = 2 * BIT_LEN;
  localparam int NP = K_LEN * K_LEN;
  localparam int CW = $clog2(K_LEN + 1);

  typedef enum logic [1:0] {K_LOAD, I_FILL, I_RUN} state_t;

  state_t                     state_q;
  logic [CW-1:0]              kcnt_q;
  logic [CW-1:0]              icnt_q;
  logic                       ready_q;
  logic                       issue_q;
  logic                       err_pend_q;
  logic                       prod_valid_q;
  logic                       o_valid_q;
  logic                       o_err_q;
  logic signed [CONV_LEN-1:0] o_data_q;
  logic signed [BIT_LEN-1:0]  kern_q [K_LEN][K_LEN];
  logic signed [BIT_LEN-1:0]  win_q  [K_LEN][K_LEN];
  logic signed [BIT_LEN-1:0]  col_in [K_LEN];
  logic signed [PW-1:0]       prod_q [NP];
  logic signed [CONV_LEN-1:0] sum_d;
  logic signed [CONV_LEN-1:0] data_d;

  genvar gi, gj;

  generate
    for (gi = 0; gi < K_LEN; gi++) begin : g_unpack
      assign col_in[gi] = bus.i_data[gi*BIT_LEN +: BIT_LEN];
    end
  endgenerate

  // Control: kernel collection, window shifting and result issue.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= K_LOAD;
      kcnt_q     <= '0;
      icnt_q     <= '0;
      ready_q    <= 1'b0;
      issue_q    <= 1'b0;
      err_pend_q <= 1'b0;
      for (int c = 0; c < K_LEN; c++) begin
        for (int r = 0; r < K_LEN; r++) begin
          kern_q[c][r] <= '0;
          win_q[c][r]  <= '0;
        end
      end
    end else begin
      issue_q    <= 1'b0;
      err_pend_q <= 1'b0;
      if (bus.i_valid) begin
        if (!bus.i_selecK_I) begin
          if (state_q == K_LOAD) begin
            for (int c = 0; c < K_LEN; c++) begin
              if (kcnt_q == CW'(c)) begin
                for (int r = 0; r < K_LEN; r++) kern_q[c][r] <= col_in[r];
              end
            end
            if (kcnt_q == CW'(K_LEN - 1)) begin
              state_q <= I_FILL;
              ready_q <= 1'b1;
              kcnt_q  <= '0;
              icnt_q  <= '0;
            end else begin
              kcnt_q <= kcnt_q + 1'b1;
            end
          end else begin
            // A kernel column mid-image restarts the kernel; the window becomes stale.
            for (int r = 0; r < K_LEN; r++) kern_q[0][r] <= col_in[r];
            kcnt_q  <= CW'(1);
            icnt_q  <= '0;
            ready_q <= 1'b0;
            state_q <= K_LOAD;
          end
        end else if (state_q == K_LOAD) begin
          err_pend_q <= 1'b1;
        end else begin
          for (int c = 0; c < K_LEN - 1; c++) begin
            for (int r = 0; r < K_LEN; r++) win_q[c][r] <= win_q[c+1][r];
          end
          for (int r = 0; r < K_LEN; r++) win_q[K_LEN-1][r] <= col_in[r];
          if (state_q == I_FILL) begin
            icnt_q <= icnt_q + 1'b1;
            if (icnt_q == CW'(K_LEN - 1)) begin
              state_q <= I_RUN;
              issue_q <= 1'b1;
            end
          end else begin
            issue_q <= 1'b1;
          end
        end
      end
    end
  end

  generate
    for (gi = 0; gi < K_LEN; gi++) begin : g_col
      for (gj = 0; gj < K_LEN; gj++) begin : g_row
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] b_ext;
        assign a_ext = PW'(win_q[gi][gj]);
        assign b_ext = PW'(kern_q[gi][gj]);
        always_ff @(posedge i_clk) begin
          if (i_reset) prod_q[gi*K_LEN+gj] <= '0;
          else         prod_q[gi*K_LEN+gj] <= a_ext * b_ext;
        end
      end
    end
  endgenerate

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NP; i++) sum_d = sum_d + CONV_LEN'(prod_q[i]);
  end

`ifdef CONV_RELU_EN
  assign data_d = sum_d[CONV_LEN-1] ? '0 : sum_d;
`else
  assign data_d = sum_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prod_valid_q <= 1'b0;
      o_valid_q    <= 1'b0;
      o_err_q      <= 1'b0;
      o_data_q     <= '0;
    end else begin
      prod_valid_q <= issue_q;
      o_valid_q    <= prod_valid_q;
      o_err_q      <= err_pend_q;
      if (prod_valid_q) o_data_q <= data_d;
    end
  end

  assign bus.o_data         = o_data_q;
  assign bus.o_valid        = o_valid_q;
  assign bus.o_kernel_ready = ready_q;
  assign bus.o_err          = o_err_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: column-list reference model checked every cycle, directed and random stimulus.
module tb_conv2d_stream;
  localparam int B   = 8;
  localparam int K   = 3;
  localparam int CL  = 20;
  localparam int B5  = 4;
  localparam int K5  = 5;
  localparam int CL5 = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv2d_stream_if #(.BIT_LEN(B),  .K_LEN(K),  .CONV_LEN(CL))  bus ();
  conv2d_stream_if #(.BIT_LEN(B5), .K_LEN(K5), .CONV_LEN(CL5)) bus5 ();

  conv2d_stream #(.BIT_LEN(B), .K_LEN(K), .CONV_LEN(CL)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );
  conv2d_stream #(.BIT_LEN(B5), .K_LEN(K5), .CONV_LEN(CL5)) dut5 (
    .i_clk(clk), .i_reset(rst), .bus(bus5)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { int cyc; longint val; } exp_t;

  // Reference model: kernel as a list of columns, image columns since the kernel completed.
  int               edge_n = 0;
  bit               live = 0;
  int               kn = 0;
  bit               mready = 0;
  logic [K*B-1:0]   kcols [K];
  logic [K*B-1:0]   imgs [$];
  exp_t             expq [$];
  int               errq [$];
  longint           hold = 0;
  longint           obs [$];
  longint           obs5 [$];
  int               err_seen = 0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic longint px(logic [K*B-1:0] col, int r);
    logic signed [B-1:0] v;
    v = col[r*B +: B];
    return longint'(v);
  endfunction

  function automatic longint conv_now();
    longint s = 0;
    int base = imgs.size() - K;
    for (int c = 0; c < K; c++)
      for (int r = 0; r < K; r++)
        s += px(imgs[base+c], r) * px(kcols[c], r);
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic model_reset();
    kn = 0;
    mready = 0;
    imgs.delete();
    expq.delete();
    errq.delete();
    hold = 0;
    live = 1;
  endtask

  task automatic model_accept(logic sel, logic [K*B-1:0] d);
    if (!sel) begin
      if (mready) begin
        kn = 0;
        mready = 0;
        imgs.delete();
      end
      kcols[kn] = d;
      kn++;
      if (kn == K) begin
        mready = 1;
        imgs.delete();
      end
    end else if (!mready) begin
      errq.push_back(edge_n + 1);
    end else begin
      imgs.push_back(d);
      if (imgs.size() > K) void'(imgs.pop_front());
      if (imgs.size() == K) expq.push_back('{edge_n + 2, conv_now()});
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (rst) model_reset();
    else if (bus.i_valid) model_accept(bus.i_selecK_I, bus.i_data);
    #1;
  endtask

  always @(negedge clk) begin
    bit ev;
    bit ee;
    if (live) begin
      ev = (expq.size() > 0 && expq[0].cyc == edge_n);
      chk("o_valid", longint'(bus.o_valid), longint'(ev));
      if (ev) begin
        hold = expq[0].val;
        void'(expq.pop_front());
      end
      chk("o_data", longint'($signed(bus.o_data)), hold);
      if (bus.o_valid === 1'b1) obs.push_back(longint'($signed(bus.o_data)));
      chk("o_kernel_ready", longint'(bus.o_kernel_ready), longint'(mready));
      ee = (errq.size() > 0 && errq[0] == edge_n);
      chk("o_err", longint'(bus.o_err), longint'(ee));
      if (ee) void'(errq.pop_front());
      if (bus.o_err === 1'b1) err_seen++;
      if (bus5.o_valid === 1'b1) obs5.push_back(longint'($signed(bus5.o_data)));
    end
  end

  function automatic logic [K*B-1:0] col_all(int v);
    logic [K*B-1:0] c;
    logic [B-1:0] e;
    e = B'(v);
    for (int r = 0; r < K; r++) c[r*B +: B] = e;
    return c;
  endfunction

  function automatic logic [K5*B5-1:0] col5_all(int v);
    logic [K5*B5-1:0] c;
    logic [B5-1:0] e;
    e = B5'(v);
    for (int r = 0; r < K5; r++) c[r*B5 +: B5] = e;
    return c;
  endfunction

  task automatic beat(logic sel, logic [K*B-1:0] d);
    bus.i_valid    = 1'b1;
    bus.i_selecK_I = sel;
    bus.i_data     = d;
    step();
    bus.i_valid    = 1'b0;
  endtask

  task automatic beat5(logic sel, logic [K5*B5-1:0] d);
    bus5.i_valid    = 1'b1;
    bus5.i_selecK_I = sel;
    bus5.i_data     = d;
    step();
    bus5.i_valid    = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_obs(string name, longint e[$]);
    chk({name, "_count"}, obs.size(), e.size());
    for (int i = 0; i < e.size() && i < obs.size(); i++) chk(name, obs[i], e[i]);
    obs.delete();
  endtask

  task automatic load_kernel123();
    for (int k = 1; k <= 3; k++) beat(1'b0, col_all(k));
  endtask

  initial begin
    longint e[$];
    int err0;
    int r;
    bus.i_valid = 1'b0; bus.i_selecK_I = 1'b0; bus.i_data = '0;
    bus5.i_valid = 1'b0; bus5.i_selecK_I = 1'b0; bus5.i_data = '0;

    idle(2);
    rst = 1'b0;
    idle(1);
    chk("reset_o_data", longint'(bus.o_data), 0);
    chk("reset_o_ready", longint'(bus.o_kernel_ready), 0);
    obs.delete();

    // Spaced beats.
    load_kernel123();
    for (int a = 1; a <= 6; a++) begin
      beat(1'b1, col_all(a));
      idle(1);
    end
    idle(3);
    e = '{42, 60, 78, 96};
    check_obs("basic_spaced", e);

    // Back-to-back beats.
    load_kernel123();
    for (int a = 1; a <= 6; a++) beat(1'b1, col_all(a));
    idle(3);
    check_obs("basic_b2b", e);

    // Signed arithmetic.
    for (int k = 0; k < 3; k++) beat(1'b0, col_all(8'hFF));
    for (int a = 0; a < 3; a++) beat(1'b1, col_all(127));
    idle(3);
`ifdef CONV_RELU_EN
    e = '{0};
`else
    e = '{-1143};
`endif
    check_obs("signed", e);

    // Image beat with no kernel.
    do_reset();
    err0 = err_seen;
    beat(1'b1, col_all(5));
    idle(3);
    chk("err_pulses", err_seen - err0, 1);
    chk("err_ready", longint'(bus.o_kernel_ready), 0);
    for (int k = 0; k < 3; k++) beat(1'b0, col_all(1));
    for (int a = 0; a < 3; a++) beat(1'b1, col_all(1));
    idle(3);
    e = '{9};
    check_obs("after_err", e);

    // Kernel reload mid-stream.
    load_kernel123();
    for (int a = 1; a <= 4; a++) beat(1'b1, col_all(a));
    idle(3);
    e = '{42, 60};
    check_obs("pre_reload", e);
    beat(1'b0, col_all(0));
    chk("reload_ready_drop", longint'(bus.o_kernel_ready), 0);
    beat(1'b0, col_all(0));
    beat(1'b0, col_all(0));
    for (int a = 7; a <= 9; a++) beat(1'b1, col_all(a));
    idle(3);
    e = '{0};
    check_obs("reload", e);

    // Reset one cycle after the third image beat.
    load_kernel123();
    for (int a = 1; a <= 3; a++) beat(1'b1, col_all(a));
    do_reset();
    idle(4);
    chk("midreset_results", obs.size(), 0);
    chk("midreset_ready", longint'(bus.o_kernel_ready), 0);
    chk("midreset_o_data", longint'(bus.o_data), 0);
    obs.delete();

    // Randomized traffic.
    repeat (600) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       beat(1'b0, K*B'($urandom()));
      else if (r < 72) beat(1'b1, K*B'($urandom()));
      else if (r < 74) do_reset();
      else             idle(1);
    end
    idle(4);
    obs.delete();

    // Second instance: K_LEN=5, BIT_LEN=4.
    do_reset();
    for (int k = 0; k < K5; k++) beat5(1'b0, col5_all(1));
    for (int a = 0; a < 7; a++) beat5(1'b1, col5_all(1));
    idle(4);
    chk("k5_count", obs5.size(), 3);
    foreach (obs5[i]) chk("k5_data", obs5[i], 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv2d_stream.md
# conv2d_stream

Parametrised streaming 2-D convolution engine, the successor to the fixed 3x3, 8-bit `convolution` block. It accepts one K_LEN-tall pixel column per `i_valid` beat, holds a K_LEN x K_LEN signed kernel, and slides a K_LEN-wide window across the image with stride 1. It produces one signed result per image column once the window is full. The datapath is a two-stage pipeline (multiply, adder tree) with an explicit output strobe. The block sits between the line-buffer/column feeder and the activation/pooling stage.

## Interface
- `BIT_LEN`, 8, signed width of each pixel and each kernel coefficient
- `K_LEN`, 3, kernel size (K_LEN x K_LEN), legal 2..7
- `CONV_LEN`, 20, output width; must be >= 2*BIT_LEN + clog2(K_LEN*K_LEN)
- `i_clk` in 1, single clock, rising edge
- `i_reset` in 1, synchronous, active-high
- `i_valid` in 1, column strobe; one column accepted per cycle it is high
- `i_selecK_I` in 1, 0 = kernel column, 1 = image column; sampled with `i_valid`
- `i_data` in K_LEN*BIT_LEN, packed column, row 0 in bits [BIT_LEN-1:0]
- `o_data` out CONV_LEN, signed convolution result
- `o_valid` out 1, one-cycle strobe qualifying `o_data`
- `o_kernel_ready` out 1, high while a complete kernel is held
- `o_err` out 1, one-cycle pulse when an image column is dropped

## Operation
- Reset values: `o_data`=0, `o_valid`=0, `o_kernel_ready`=0, `o_err`=0. Kernel, window, counters and pipeline registers are cleared; state = K_LOAD.
- States:
  - K_LOAD: collecting kernel columns. A kernel beat writes kernel column k[kcnt] and increments `kcnt`. At kcnt = K_LEN-1 the state goes to I_FILL and `o_kernel_ready` goes to 1.
  - I_FILL: an image beat shifts the window (w[0] oldest, w[K_LEN-1] newest) and increments `icnt`. When the K_LEN-th column is accepted, the state goes to I_RUN and a result is issued for that column.
  - I_RUN: every image beat shifts the window and issues a result.
- Kernel beat in I_FILL or I_RUN: starts a new kernel.
  - Clear `kcnt` and `icnt`, drop `o_kernel_ready`, and write the beat as k[0].
  - Go to K_LOAD; if K_LEN = 1 is ever allowed, this would complete immediately.
  - Window contents are treated as invalid.
  - Results already in the pipeline still emerge.
- Image beat in K_LOAD: the column is discarded, `o_err` pulses on the next cycle, and state and counters are unchanged.
- Arithmetic: result = sum over c, r of w[c][r] * k[c][r].
  - All operands are signed two's complement.
  - Products are 2*BIT_LEN wide, and the sum is sign-extended to CONV_LEN.
  - No overflow is possible for legal CONV_LEN.
- Stage 1 registers all K_LEN² products. Stage 2 registers the adder-tree sum into `o_data`.
- `o_data` holds its last value while `o_valid` is low.

## Timing
- A beat is accepted at rising edge N when `i_valid`=1.
- The window/kernel is updated at edge N, products are registered at N+1, and `o_data`/`o_valid` are registered at N+2. Latency is 2 cycles.
- Back-to-back beats on consecutive cycles are supported at full throughput, with one result per cycle in I_RUN.
- `o_kernel_ready` rises at the edge that accepts the last kernel column. It falls at the edge that accepts a new kernel column.
- `o_err` is high for exactly one cycle, at N+1.
- `i_reset` asserted at any edge:
  - Clears everything at that edge, including in-flight pipeline results.
  - No `o_valid` is produced for any beat accepted before reset.
  - `i_valid` is ignored while `i_reset`=1.

## Configuration
- `CONV_RELU_EN` defined: stage 2 clamps negative sums to 0 before registering `o_data`. The output is always >= 0, and latency is unchanged.
- Not defined: `o_data` is the raw signed sum.

## Test plan
- Basic 3x3 slide (defaults):
  - Load kernel columns all-1, all-2, all-3, then image columns all-1, all-2, all-3, all-4, all-5, all-6.
  - Expect `o_valid` pulses 2 cycles after the 3rd..6th image beats with `o_data` = 42, 60, 78, 96.
  - Expect no `o_valid` for the first two image beats.
- Back-to-back beats: the same stimulus with `i_valid` held high continuously gives four consecutive `o_valid` cycles with 42, 60, 78, 96.
- Signed:
  - Kernel columns all -1 (8'hFF), image columns all 127.
  - Expect -1143 (20'hFFB89) without `CONV_RELU_EN`; expect 0 with it.
- Error path: an image beat before any kernel gives a one-cycle `o_err`, no `o_valid`, and `o_kernel_ready`=0. A subsequent full kernel load still works.
- Kernel reload mid-stream:
  - After 4 image columns, load a new kernel of all-0.
  - `o_kernel_ready` drops on the first kernel beat.
  - Two fresh image columns produce no output; the third gives `o_data` = 0.
- Reset mid-pipeline: assert `i_reset` one cycle after the 3rd image beat. Expect no `o_valid`, all outputs 0 the following cycle, and state K_LOAD.
- Run the suite additionally with `K_LEN`=5, `BIT_LEN`=4, `CONV_LEN`=13, all-1 kernel and all-1 image, expecting `o_data` = 25 per result.
